// File: rtl/multi_clk_pkg.sv
// Shared types, reset defaults and config-write validation for the multi-channel clock generator.
// Pure declarations: no latency, no flow control.
package multi_clk_pkg;

  localparam int DEFAULT_CNT_W = 8;
  localparam int DEFAULT_DIV   = 25;
  localparam int DEFAULT_HI    = 13;

  typedef logic [DEFAULT_CNT_W-1:0] div_t;
  typedef logic [DEFAULT_CNT_W-1:0] hi_t;

  // A write is accepted only if it names a real channel and the high time fits strictly inside the period.
  function automatic logic cfg_valid(input int unsigned ch, input int unsigned n_ch,
                                     input int unsigned div, input int unsigned hi);
    return (ch < n_ch) && (div >= 2) && (hi >= 1) && (hi < div);
  endfunction

endpackage

// File: rtl/clk_div_ch.sv
// One divided-clock channel with shadow config that loads only at a period boundary or while idle.
// Outputs registered, one cycle after the counter state; no backpressure.
module clk_div_ch
  import multi_clk_pkg::*;
#(
  parameter int CNT_W   = DEFAULT_CNT_W,
  parameter int DEF_DIV = DEFAULT_DIV,
  parameter int DEF_HI  = DEFAULT_HI
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_div,
  input  logic [CNT_W-1:0] wr_hi,
  output logic             pend,
  output logic             clk_out,
  output logic             tick
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] div;
  logic [CNT_W-1:0] hi;
  logic [CNT_W-1:0] sdiv;
  logic [CNT_W-1:0] shi;
  logic             wrap;
  logic             load;

  assign wrap = en && (cnt == div - CNT_W'(1));
  assign load = pend && (wrap || !en);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      div     <= CNT_W'(DEF_DIV);
      hi      <= CNT_W'(DEF_HI);
      sdiv    <= CNT_W'(DEF_DIV);
      shi     <= CNT_W'(DEF_HI);
      pend    <= 1'b0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else begin
      if (en) begin
        clk_out <= (cnt < hi);
        tick    <= (cnt == '0);
        cnt     <= wrap ? '0 : cnt + CNT_W'(1);
      end else begin
        cnt     <= '0;
        clk_out <= 1'b0;
        tick    <= 1'b0;
      end
      if (load) begin
        div  <= sdiv;
        hi   <= shi;
        pend <= 1'b0;
      end
      // A write landing on a load cycle is applied after the load, so it waits for the next boundary.
      if (wr) begin
        sdiv <= wr_div;
        shi  <= wr_hi;
        pend <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/multi_clk_genr.sv
// N_CH independent programmable clock dividers with validated, boundary-synchronised config writes.
// cfg_err/cfg_pend one cycle after cfg_we, clk_out/tick registered; writes are never stalled.
module multi_clk_genr
  import multi_clk_pkg::*;
#(
  parameter int N_CH    = 4,
  parameter int CNT_W   = DEFAULT_CNT_W,
  parameter int DEF_DIV = DEFAULT_DIV,
  parameter int DEF_HI  = DEFAULT_HI
) (
  input  logic                                      CLK100MHZ,
  input  logic                                      CPU_RESETN,
  input  logic [N_CH-1:0]                           ch_en,
  input  logic                                      cfg_we,
  input  logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] cfg_ch,
  input  logic [CNT_W-1:0]                          cfg_div,
  input  logic [CNT_W-1:0]                          cfg_hi,
  output logic                                      cfg_err,
  output logic [N_CH-1:0]                           cfg_pend,
  output logic [N_CH-1:0]                           clk_out,
  output logic [N_CH-1:0]                           tick
);

  logic wr_ok;

  assign wr_ok = cfg_we && cfg_valid(32'(cfg_ch), N_CH, 32'(cfg_div), 32'(cfg_hi));

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= cfg_we && !wr_ok;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    clk_div_ch #(
      .CNT_W  (CNT_W),
      .DEF_DIV(DEF_DIV),
      .DEF_HI (DEF_HI)
    ) u_ch (
      .clk    (CLK100MHZ),
      .rst_n  (CPU_RESETN),
      .en     (ch_en[i]),
      .wr     (wr_ok && (32'(cfg_ch) == 32'(i))),
      .wr_div (cfg_div),
      .wr_hi  (cfg_hi),
      .pend   (cfg_pend[i]),
      .clk_out(clk_out[i]),
      .tick   (tick[i])
    );
  end

endmodule

// File: tb/tb_multi_clk_genr.sv
// Directed bench for multi_clk_genr: defaults, reload, rejected writes, boundary writes, disable and reset.
module tb_multi_clk_genr;

  localparam int N_CH  = 5;
  localparam int CNT_W = 8;

  logic             CLK100MHZ = 1'b0;
  logic             CPU_RESETN;
  logic [N_CH-1:0]  ch_en;
  logic             cfg_we;
  logic [2:0]       cfg_ch;
  logic [CNT_W-1:0] cfg_div;
  logic [CNT_W-1:0] cfg_hi;
  logic             cfg_err;
  logic [N_CH-1:0]  cfg_pend;
  logic [N_CH-1:0]  clk_out;
  logic [N_CH-1:0]  tick;

  int checks = 0;
  int errors = 0;

  multi_clk_genr #(.N_CH(N_CH), .CNT_W(CNT_W), .DEF_DIV(25), .DEF_HI(13)) dut (
    .CLK100MHZ (CLK100MHZ),
    .CPU_RESETN(CPU_RESETN),
    .ch_en     (ch_en),
    .cfg_we    (cfg_we),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .cfg_hi    (cfg_hi),
    .cfg_err   (cfg_err),
    .cfg_pend  (cfg_pend),
    .clk_out   (clk_out),
    .tick      (tick)
  );

  always #5 CLK100MHZ = ~CLK100MHZ;

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic step;
    @(posedge CLK100MHZ);
    #1;
  endtask

  task automatic wr_cfg(input int ch, input int div, input int hi);
    cfg_we  = 1'b1;
    cfg_ch  = 3'(ch);
    cfg_div = CNT_W'(div);
    cfg_hi  = CNT_W'(hi);
    step;
    cfg_we  = 1'b0;
  endtask

  task automatic wait_tick(input int ch, output int waited);
    waited = -1;
    for (int n = 1; n <= 200; n++) begin
      step;
      if (tick[ch]) begin
        waited = n;
        break;
      end
    end
  endtask

  // Starts on a tick sample, ends on the next tick sample of the same channel.
  task automatic measure(input int ch, output int hi_n, output int per);
    hi_n = clk_out[ch] ? 1 : 0;
    per  = 1;
    for (int n = 0; n < 300; n++) begin
      step;
      if (tick[ch]) break;
      per++;
      hi_n += clk_out[ch] ? 1 : 0;
    end
  endtask

  task automatic test_reset;
    CPU_RESETN = 1'b1;
    ch_en = '0; cfg_we = 1'b0; cfg_ch = '0; cfg_div = '0; cfg_hi = '0;
    #2 CPU_RESETN = 1'b0;
    repeat (3) step;
    checks++; if (clk_out !== '0) begin errors++; $display("FAIL reset_clk_out got %b want 0", clk_out); end
    checks++; if (tick !== '0) begin errors++; $display("FAIL reset_tick got %b want 0", tick); end
    checks++; if (cfg_pend !== '0) begin errors++; $display("FAIL reset_pend got %b want 0", cfg_pend); end
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", cfg_err); end
    CPU_RESETN = 1'b1;
    step;
  endtask

  task automatic test_default;
    int hi_run, lo_run, extra;
    ch_en[0] = 1'b1;
    step;
    checks++; if (clk_out[0] !== 1'b1) begin errors++; $display("FAIL default_first_clk got %b want 1", clk_out[0]); end
    checks++; if (tick[0] !== 1'b1) begin errors++; $display("FAIL default_first_tick got %b want 1", tick[0]); end
    hi_run = 1; lo_run = 0; extra = 0;
    for (int n = 0; n < 12; n++) begin
      step;
      hi_run += clk_out[0] ? 1 : 0;
      extra  += tick[0] ? 1 : 0;
    end
    for (int n = 0; n < 12; n++) begin
      step;
      lo_run += clk_out[0] ? 0 : 1;
      extra  += tick[0] ? 1 : 0;
    end
    checks++; if (hi_run != 13) begin errors++; $display("FAIL default_high got %0d want 13", hi_run); end
    checks++; if (lo_run != 12) begin errors++; $display("FAIL default_low got %0d want 12", lo_run); end
    checks++; if (extra != 0) begin errors++; $display("FAIL default_extra_ticks got %0d want 0", extra); end
    step;
    checks++; if (tick[0] !== 1'b1) begin errors++; $display("FAIL default_period_tick got %b want 1", tick[0]); end
  endtask

  task automatic test_reload;
    int w, h, p;
    ch_en[1] = 1'b1;
    step;
    repeat (4) step;
    wr_cfg(1, 10, 5);
    checks++; if (cfg_pend[1] !== 1'b1) begin errors++; $display("FAIL reload_pend got %b want 1", cfg_pend[1]); end
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL reload_err got %b want 0", cfg_err); end
    wait_tick(1, w);
    checks++; if (w != 20) begin errors++; $display("FAIL reload_old_period_end got %0d want 20", w); end
    checks++; if (cfg_pend[1] !== 1'b0) begin errors++; $display("FAIL reload_pend_clear got %b want 0", cfg_pend[1]); end
    measure(1, h, p);
    checks++; if (h != 5) begin errors++; $display("FAIL reload_high got %0d want 5", h); end
    checks++; if (p != 10) begin errors++; $display("FAIL reload_period got %0d want 10", p); end
  endtask

  task automatic test_invalid;
    int ch_t[4]  = '{1, 1, 1, 5};
    int div_t[4] = '{1, 10, 8, 10};
    int hi_t[4]  = '{1, 0, 8, 4};
    int w, h, p;
    for (int k = 0; k < 4; k++) begin
      wr_cfg(ch_t[k], div_t[k], hi_t[k]);
      checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL invalid%0d_err got %b want 1", k, cfg_err); end
      checks++; if (cfg_pend !== '0) begin errors++; $display("FAIL invalid%0d_pend got %b want 0", k, cfg_pend); end
      step;
      checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL invalid%0d_err_pulse got %b want 0", k, cfg_err); end
    end
    wait_tick(1, w);
    checks++; if (w < 1) begin errors++; $display("FAIL invalid_tick_timeout got %0d want >0", w); end
    measure(1, h, p);
    checks++; if (h != 5) begin errors++; $display("FAIL invalid_keep_high got %0d want 5", h); end
    checks++; if (p != 10) begin errors++; $display("FAIL invalid_keep_period got %0d want 10", p); end
  endtask

  task automatic test_back_to_back;
    int w, h, p;
    ch_en[2] = 1'b1;
    repeat (24) step;
    wr_cfg(2, 6, 3);
    checks++; if (cfg_pend[2] !== 1'b1) begin errors++; $display("FAIL b2b_pend_a got %b want 1", cfg_pend[2]); end
    repeat (2) step;
    wr_cfg(2, 8, 2);
    checks++; if (cfg_pend[2] !== 1'b1) begin errors++; $display("FAIL b2b_pend_b got %b want 1", cfg_pend[2]); end
    wait_tick(2, w);
    checks++; if (w != 23) begin errors++; $display("FAIL b2b_old_period got %0d want 23", w); end
    checks++; if (cfg_pend[2] !== 1'b0) begin errors++; $display("FAIL b2b_pend_clear got %b want 0", cfg_pend[2]); end
    measure(2, h, p);
    checks++; if (h != 2) begin errors++; $display("FAIL b2b_last_high got %0d want 2", h); end
    checks++; if (p != 8) begin errors++; $display("FAIL b2b_last_period got %0d want 8", p); end
    wr_cfg(2, 12, 6);
    repeat (5) step;
    wr_cfg(2, 4, 1);
    checks++; if (cfg_pend[2] !== 1'b1) begin errors++; $display("FAIL b2b_load_write_pend got %b want 1", cfg_pend[2]); end
    wait_tick(2, w);
    checks++; if (w != 1) begin errors++; $display("FAIL b2b_load_tick got %0d want 1", w); end
    measure(2, h, p);
    checks++; if (h != 6 || p != 12) begin errors++; $display("FAIL b2b_preshadow got %0d/%0d want 6/12", h, p); end
    checks++; if (cfg_pend[2] !== 1'b0) begin errors++; $display("FAIL b2b_second_clear got %b want 0", cfg_pend[2]); end
    measure(2, h, p);
    checks++; if (h != 1 || p != 4) begin errors++; $display("FAIL b2b_newshadow got %0d/%0d want 1/4", h, p); end
  endtask

  task automatic test_disable;
    int h, p, seen;
    ch_en[3] = 1'b1;
    step;
    repeat (4) step;
    wr_cfg(3, 6, 2);
    checks++; if (clk_out[3] !== 1'b1) begin errors++; $display("FAIL dis_mid_high got %b want 1", clk_out[3]); end
    ch_en[3] = 1'b0;
    step;
    checks++; if (clk_out[3] !== 1'b0) begin errors++; $display("FAIL dis_clk_off got %b want 0", clk_out[3]); end
    checks++; if (cfg_pend[3] !== 1'b0) begin errors++; $display("FAIL dis_load got %b want 0", cfg_pend[3]); end
    seen = 0;
    repeat (3) begin
      step;
      seen += (clk_out[3] || tick[3]) ? 1 : 0;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL dis_idle got %0d want 0", seen); end
    ch_en[3] = 1'b1;
    step;
    checks++; if (tick[3] !== 1'b1 || clk_out[3] !== 1'b1) begin errors++; $display("FAIL dis_restart got %b%b want 11", tick[3], clk_out[3]); end
    measure(3, h, p);
    checks++; if (h != 2 || p != 6) begin errors++; $display("FAIL dis_new_cfg got %0d/%0d want 2/6", h, p); end
  endtask

  task automatic test_async_reset;
    int w, h, p;
    wait_tick(0, w);
    checks++; if (w < 1) begin errors++; $display("FAIL ares_tick_timeout got %0d want >0", w); end
    wr_cfg(0, 20, 4);
    checks++; if (cfg_pend[0] !== 1'b1 || clk_out[0] !== 1'b1) begin errors++; $display("FAIL ares_pre got %b%b want 11", cfg_pend[0], clk_out[0]); end
    #2 CPU_RESETN = 1'b0;
    #1;
    checks++; if (clk_out !== '0 || tick !== '0) begin errors++; $display("FAIL ares_outputs got %b/%b want 0", clk_out, tick); end
    checks++; if (cfg_pend !== '0) begin errors++; $display("FAIL ares_pend got %b want 0", cfg_pend); end
    repeat (2) step;
    CPU_RESETN = 1'b1;
    step;
    checks++; if (clk_out !== 5'b01111 || tick !== 5'b01111) begin errors++; $display("FAIL ares_restart got %b/%b want 01111", clk_out, tick); end
    measure(0, h, p);
    checks++; if (h != 13 || p != 25) begin errors++; $display("FAIL ares_ch0_default got %0d/%0d want 13/25", h, p); end
    checks++; if (cfg_pend !== '0) begin errors++; $display("FAIL ares_pend_after got %b want 0", cfg_pend); end
    measure(1, h, p);
    checks++; if (h != 13 || p != 25) begin errors++; $display("FAIL ares_ch1_default got %0d/%0d want 13/25", h, p); end
  endtask

  initial begin
    test_reset;
    test_default;
    test_reload;
    test_invalid;
    test_back_to_back;
    test_disable;
    test_async_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
